// File: rtl/jk_sequence_driver_pkg.sv
// Shared definitions for the JK sequence driver: FSM state encodings and
// the J/K drive constants used when the flop bank must hold its state.
package jk_sequence_driver_pkg;

    // FSM state encodings (IDLE=0, DRIVE=1, CHECK=2, FINISH=3).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Per-bit J/K levels: HOLD leaves a flop unchanged, SET is the active level.
    localparam logic JK_HOLD = 1'b0;
    localparam logic JK_SET  = 1'b1;

endpackage

// File: rtl/jk_excitation.sv
// JK excitation table, WIDTH bits wide and purely combinational.
// Don't-care terms are resolved to 0, so toggle (J=K=1) is never produced:
//   q->t  0->0: 00   0->1: 10   1->0: 01   1->1: 00   (shown as J,K)
module jk_excitation
    import jk_sequence_driver_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    // Set only where a 0 must become 1, reset only where a 1 must become 0.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            j[i] = (!q[i] &&  t[i]) ? JK_SET : JK_HOLD;
            k[i] = ( q[i] && !t[i]) ? JK_SET : JK_HOLD;
        end
    end

endmodule

// File: rtl/jk_sequence_driver.sv
// Drive-and-check block for a bank of JK flip-flops. A programmed table of
// target states is stepped through: each step spends one cycle driving the
// J/K needed to reach the target and one cycle (flops holding) comparing the
// observed Q against it. Failed checks are counted for the current run.
//
// Handshake: load_en and start are single-cycle requests, accepted only while
// busy=0 (state IDLE); requests seen while busy are dropped with no effect.
// done is a one-cycle pulse coinciding with busy falling.
module jk_sequence_driver
    import jk_sequence_driver_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int IDXW  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [IDXW-1:0]   load_addr,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              start,
    input  logic [IDXW:0]     seq_len,
    input  logic [WIDTH-1:0]  q_obs,
    output logic [WIDTH-1:0]  j_out,
    output logic [WIDTH-1:0]  k_out,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [IDXW:0]     err_count,
    output logic [IDXW-1:0]   step_idx,
    output state_t            fsm_state
);

    localparam int LENW = IDXW + 1;

    state_t             state;
    logic [LENW-1:0]    len_q;
    logic [WIDTH-1:0]   seq_table [DEPTH];

    logic               load_ok;
    logic               start_ok;
    logic               last_step;
    logic [LENW-1:0]    len_clamped;
    logic [WIDTH-1:0]   next_tgt;
    logic [WIDTH-1:0]   exc_j;
    logic [WIDTH-1:0]   exc_k;

    assign fsm_state   = state;
    assign load_ok     = load_en && (state == ST_IDLE);
    assign start_ok    = start && (state == ST_IDLE);
    assign last_step   = ({1'b0, step_idx} == (len_q - LENW'(1)));
    assign len_clamped = (seq_len > LENW'(DEPTH)) ? LENW'(DEPTH) : seq_len;

    // Target of the step about to be driven. On the start edge a same-cycle
    // write to entry 0 is forwarded, so the freshly loaded value is used.
    always_comb begin
        next_tgt = '0;
        if (state == ST_IDLE) begin
            next_tgt = (load_ok && (load_addr == '0)) ? load_data : seq_table[0];
        end else if (state == ST_CHECK && !last_step) begin
            next_tgt = seq_table[IDXW'(step_idx + 1'b1)];
        end
    end

    // Excitation for the next step; Q is stable here because the flops hold
    // during IDLE and CHECK, the only states that launch a DRIVE.
    jk_excitation #(
        .WIDTH (WIDTH)
    ) u_excitation (
        .q (q_obs),
        .t (next_tgt),
        .j (exc_j),
        .k (exc_k)
    );

    // Sequence table: cleared by reset, writable only while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                seq_table[i] <= '0;
            end
        end else if (load_ok) begin
            seq_table[load_addr] <= load_data;
        end
    end

    // Sequencer FSM with registered J/K, status and error counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            j_out     <= '0;
            k_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            step_idx  <= '0;
            len_q     <= '0;
        end else begin
            done  <= 1'b0;
            j_out <= {WIDTH{JK_HOLD}};
            k_out <= {WIDTH{JK_HOLD}};
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_q     <= len_clamped;
                        mismatch  <= 1'b0;
                        err_count <= '0;
                        step_idx  <= '0;
                        busy      <= 1'b1;
                        if (len_clamped == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state <= ST_DRIVE;
                            j_out <= exc_j;
                            k_out <= exc_k;
                        end
                    end
                end
                ST_DRIVE: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (q_obs != seq_table[step_idx]) begin
                        mismatch  <= 1'b1;
                        err_count <= err_count + LENW'(1);
                    end
                    if (last_step) begin
                        state <= ST_FINISH;
                    end else begin
                        step_idx <= step_idx + 1'b1;
                        state    <= ST_DRIVE;
                        j_out    <= exc_j;
                        k_out    <= exc_k;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
